// File: rtl/arithmetic_div_seq_if.sv
// Handshake bundle for the sequential divider.
// Ports: start/signed_op/in_a/in_b toward the divider; busy/done/flags/result back.
interface arithmetic_div_seq_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic                 signed_op;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic                 busy;
  logic                 done;
  logic                 div_by_zero;
  logic                 overflow;
  logic [2*WIDTH-1:0]   result;

  modport master (
    output start,
    output signed_op,
    output in_a,
    output in_b,
    input  busy,
    input  done,
    input  div_by_zero,
    input  overflow,
    input  result
  );

  modport slave (
    input  start,
    input  signed_op,
    input  in_a,
    input  in_b,
    output busy,
    output done,
    output div_by_zero,
    output overflow,
    output result
  );
endinterface

// File: rtl/arithmetic_div_seq.sv
// Non-restoring sequential divider, one quotient bit per clock, signed or unsigned.
// Ports: clock, clear (sync active-high), bus (slave): start/operands in, busy/done/flags/result out.
module arithmetic_div_seq #(
  parameter int WIDTH = 32
) (
  input logic                clock,
  input logic                clear,
  arithmetic_div_seq_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [WIDTH:0]       a_q, a_nx;
  logic [WIDTH-1:0]     q_q, q_nx;
  logic [WIDTH-1:0]     m_q, m_nx;
  logic [CW-1:0]        cnt_q, cnt_nx;
  logic                 sg_q, sg_nx;
  logic                 na_q, na_nx;
  logic                 nb_q, nb_nx;
  logic                 ov_q, ov_nx;

  logic                 busy_q, busy_nx;
  logic                 done_q, done_nx;
  logic                 dbz_q, dbz_nx;
  logic                 ovf_q, ovf_nx;
  logic [2*WIDTH-1:0]   res_q, res_nx;

  logic                 accept;
  logic                 neg_a_in;
  logic                 neg_b_in;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic                 ovf_in;
  logic [WIDTH:0]       sh;
  logic [WIDTH:0]       step;
  logic [WIDTH-1:0]     a_fix;
  logic [WIDTH-1:0]     q_fin;
  logic [WIDTH-1:0]     r_fin;

  // busy mirrors RUN/FIX, so accept covers both IDLE and DONE
  assign accept   = bus.start && !busy_q;

  assign neg_a_in = bus.signed_op && bus.in_a[WIDTH-1];
  assign neg_b_in = bus.signed_op && bus.in_b[WIDTH-1];

  // |MIN| wraps to MIN, which is 2^(W-1) read as unsigned
  assign mag_a    = neg_a_in ? -bus.in_a : bus.in_a;
  assign mag_b    = neg_b_in ? -bus.in_b : bus.in_b;

  assign ovf_in   = bus.signed_op
                 && (bus.in_a == MIN)
                 && (bus.in_b == ONES);

  // partial remainder sign chooses add or subtract for this bit
  assign sh       = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign step     = a_q[WIDTH]
                  ? sh + {1'b0, m_q}
                  : sh - {1'b0, m_q};

  // final restore lands in [0, M), so W bits suffice
  assign a_fix    = a_q[WIDTH]
                  ? a_q[WIDTH-1:0] + m_q
                  : a_q[WIDTH-1:0];

  assign q_fin    = (sg_q && (na_q ^ nb_q)) ? -q_q : q_q;
  assign r_fin    = (sg_q && na_q) ? -a_fix : a_fix;

  always_comb begin
    state_nx = state;
    a_nx     = a_q;
    q_nx     = q_q;
    m_nx     = m_q;
    cnt_nx   = cnt_q;
    sg_nx    = sg_q;
    na_nx    = na_q;
    nb_nx    = nb_q;
    ov_nx    = ov_q;
    done_nx  = 1'b0;
    dbz_nx   = dbz_q;
    ovf_nx   = ovf_q;
    res_nx   = res_q;

    case (state)
      IDLE, DONE: begin
        if (accept) begin
          sg_nx  = bus.signed_op;
          na_nx  = neg_a_in;
          nb_nx  = neg_b_in;
          a_nx   = '0;
          q_nx   = mag_a;
          m_nx   = mag_b;
          cnt_nx = CW'(WIDTH);
          ov_nx  = ovf_in;
          dbz_nx = 1'b0;
          ovf_nx = 1'b0;
          if (bus.in_b == '0) begin
            state_nx = DONE;
            dbz_nx   = 1'b1;
            done_nx  = 1'b1;
            res_nx   = {bus.in_a, ONES};
          end else begin
            state_nx = RUN;
          end
        end else begin
          state_nx = IDLE;
        end
      end

      RUN: begin
        a_nx   = step;
        q_nx   = {q_q[WIDTH-2:0], ~step[WIDTH]};
        cnt_nx = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_nx = FIX;
        end
      end

      FIX: begin
        res_nx   = {r_fin, q_fin};
        ovf_nx   = ov_q;
        done_nx  = 1'b1;
        state_nx = DONE;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign busy_nx = (state_nx == RUN) || (state_nx == FIX);

  always_ff @(posedge clock) begin
    if (clear) begin
      state  <= IDLE;
      a_q    <= '0;
      q_q    <= '0;
      m_q    <= '0;
      cnt_q  <= '0;
      sg_q   <= 1'b0;
      na_q   <= 1'b0;
      nb_q   <= 1'b0;
      ov_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      ovf_q  <= 1'b0;
      res_q  <= '0;
    end else begin
      state  <= state_nx;
      a_q    <= a_nx;
      q_q    <= q_nx;
      m_q    <= m_nx;
      cnt_q  <= cnt_nx;
      sg_q   <= sg_nx;
      na_q   <= na_nx;
      nb_q   <= nb_nx;
      ov_q   <= ov_nx;
      busy_q <= busy_nx;
      done_q <= done_nx;
      dbz_q  <= dbz_nx;
      ovf_q  <= ovf_nx;
      res_q  <= res_nx;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;
  assign bus.result      = res_q;

endmodule

// File: tb/tb_arithmetic_div_seq.sv
// Self-checking bench for arithmetic_div_seq at WIDTH=8 and WIDTH=32.
// Scoreboard queue of expected results, popped when done pulses.
module tb_arithmetic_div_seq;

  logic clock = 1'b0;
  logic clear = 1'b1;

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  arithmetic_div_seq_if #(.WIDTH(32)) d32 ();
  arithmetic_div_seq_if #(.WIDTH(8))  d8  ();

  arithmetic_div_seq #(.WIDTH(32)) u32 (
    .clock(clock),
    .clear(clear),
    .bus  (d32)
  );

  arithmetic_div_seq #(.WIDTH(8)) u8 (
    .clock(clock),
    .clear(clear),
    .bus  (d8)
  );

  typedef struct {
    int          w;
    logic [63:0] q;
    logic [63:0] r;
    logic        dbz;
    logic        ovf;
    int          e0;
  } exp_t;

  exp_t sb[$];

  function automatic logic [63:0] msk(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic void ref_div(
    input  int          w,
    input  logic        sg,
    input  logic [63:0] a_in,
    input  logic [63:0] b_in,
    output logic [63:0] q,
    output logic [63:0] r,
    output logic        dbz,
    output logic        ovf
  );
    logic [63:0] a, b;
    longint sa, sb_, sq, sr;
    a   = a_in & msk(w);
    b   = b_in & msk(w);
    dbz = 1'b0;
    ovf = 1'b0;
    if (b == 64'd0) begin
      q   = msk(w);
      r   = a;
      dbz = 1'b1;
    end else if (sg) begin
      sa  = a[w-1] ? longint'(a | ~msk(w)) : longint'(a);
      sb_ = b[w-1] ? longint'(b | ~msk(w)) : longint'(b);
      sq  = sa / sb_;
      sr  = sa % sb_;
      q   = 64'(sq) & msk(w);
      r   = 64'(sr) & msk(w);
      ovf = (a == (64'd1 << (w - 1))) && (b == msk(w));
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic drive(
    input int w, input logic st, input logic sg,
    input logic [63:0] a, input logic [63:0] b
  );
    if (w == 32) begin
      d32.start     = st;
      d32.signed_op = sg;
      d32.in_a      = a[31:0];
      d32.in_b      = b[31:0];
    end else begin
      d8.start      = st;
      d8.signed_op  = sg;
      d8.in_a       = a[7:0];
      d8.in_b       = b[7:0];
    end
  endtask

  function automatic logic get_done(input int w);
    return (w == 32) ? d32.done : d8.done;
  endfunction

  function automatic logic get_busy(input int w);
    return (w == 32) ? d32.busy : d8.busy;
  endfunction

  function automatic logic get_dbz(input int w);
    return (w == 32) ? d32.div_by_zero : d8.div_by_zero;
  endfunction

  function automatic logic get_ovf(input int w);
    return (w == 32) ? d32.overflow : d8.overflow;
  endfunction

  function automatic logic [63:0] get_q(input int w);
    return (w == 32) ? {32'd0, d32.result[31:0]}
                     : {56'd0, d8.result[7:0]};
  endfunction

  function automatic logic [63:0] get_r(input int w);
    return (w == 32) ? {32'd0, d32.result[63:32]}
                     : {56'd0, d8.result[15:8]};
  endfunction

  task automatic push_exp(
    input int w, input logic [63:0] q, input logic [63:0] r,
    input logic dbz, input logic ovf, input int e0
  );
    exp_t e;
    e.w   = w;
    e.q   = q;
    e.r   = r;
    e.dbz = dbz;
    e.ovf = ovf;
    e.e0  = e0;
    sb.push_back(e);
  endtask

  task automatic push_ref(
    input int w, input logic sg,
    input logic [63:0] a, input logic [63:0] b, input int e0
  );
    logic [63:0] q, r;
    logic dbz, ovf;
    ref_div(w, sg, a, b, q, r, dbz, ovf);
    push_exp(w, q, r, dbz, ovf, e0);
  endtask

  task automatic issue_exp(
    input int w, input logic sg,
    input logic [63:0] a, input logic [63:0] b,
    input logic [63:0] q, input logic [63:0] r,
    input logic dbz, input logic ovf
  );
    drive(w, 1'b1, sg, a, b);
    @(posedge clock);
    #1;
    drive(w, 1'b0, sg, a, b);
    push_exp(w, q, r, dbz, ovf, cyc);
  endtask

  task automatic issue(
    input int w, input logic sg,
    input logic [63:0] a, input logic [63:0] b
  );
    drive(w, 1'b1, sg, a, b);
    @(posedge clock);
    #1;
    drive(w, 1'b0, sg, a, b);
    push_ref(w, sg, a, b, cyc);
  endtask

  task automatic collect(input int w, input string name);
    exp_t e;
    int n;
    int lat;
    int lat_exp;
    n = 0;
    while (!get_done(w) && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL %s scoreboard: got empty queue, expected an entry",
               name);
      return;
    end
    e = sb.pop_front();
    if (!get_done(w)) begin
      n_err++;
      $display("FAIL %s timeout: got done=0 after 200 cycles, expected 1",
               name);
      return;
    end
    lat     = cyc - e.e0;
    lat_exp = e.dbz ? 0 : e.w + 1;
    if (lat !== lat_exp) begin
      n_err++;
      $display("FAIL %s latency: got %0d, expected %0d",
               name, lat, lat_exp);
    end
    n_vec++;
    if (get_q(w) !== e.q) begin
      n_err++;
      $display("FAIL %s quotient: got %h, expected %h",
               name, get_q(w), e.q);
    end
    n_vec++;
    if (get_r(w) !== e.r) begin
      n_err++;
      $display("FAIL %s remainder: got %h, expected %h",
               name, get_r(w), e.r);
    end
    n_vec++;
    if (get_dbz(w) !== e.dbz) begin
      n_err++;
      $display("FAIL %s div_by_zero: got %b, expected %b",
               name, get_dbz(w), e.dbz);
    end
    n_vec++;
    if (get_ovf(w) !== e.ovf) begin
      n_err++;
      $display("FAIL %s overflow: got %b, expected %b",
               name, get_ovf(w), e.ovf);
    end
    n_vec++;
    if (get_busy(w) !== 1'b0) begin
      n_err++;
      $display("FAIL %s busy_at_done: got %b, expected 0",
               name, get_busy(w));
    end
  endtask

  task automatic check_idle(input int w, input string name);
    n_vec++;
    if (get_busy(w) !== 1'b0 || get_done(w) !== 1'b0
        || get_dbz(w) !== 1'b0 || get_ovf(w) !== 1'b0) begin
      n_err++;
      $display("FAIL %s flags: got b%b d%b z%b o%b, expected all 0",
               name, get_busy(w), get_done(w), get_dbz(w), get_ovf(w));
    end
    n_vec++;
    if (get_q(w) !== 64'd0 || get_r(w) !== 64'd0) begin
      n_err++;
      $display("FAIL %s result: got %h/%h, expected 0/0",
               name, get_r(w), get_q(w));
    end
  endtask

  task automatic test_reset();
    drive(32, 1'b0, 1'b0, 64'd0, 64'd0);
    drive(8, 1'b0, 1'b0, 64'd0, 64'd0);
    clear = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_idle(32, "reset32");
    check_idle(8, "reset8");
    clear = 1'b0;
  endtask

  task automatic test_basic();
    issue_exp(32, 1'b0, 64'd7, 64'd2, 64'd3, 64'd1, 1'b0, 1'b0);
    collect(32, "u7div2");
    @(posedge clock);
    #1;
    n_vec++;
    if (d32.done !== 1'b0) begin
      n_err++;
      $display("FAIL done_pulse: got %b, expected 0", d32.done);
    end
    n_vec++;
    if (d32.result !== {32'd1, 32'd3}) begin
      n_err++;
      $display("FAIL result_hold: got %h, expected %h",
               d32.result, {32'd1, 32'd3});
    end
  endtask

  task automatic test_signed();
    issue_exp(32, 1'b1, 64'hFFFFFFF9, 64'd2,
              64'hFFFFFFFD, 64'hFFFFFFFF, 1'b0, 1'b0);
    collect(32, "s-7div2");
    issue_exp(32, 1'b1, 64'd7, 64'hFFFFFFFE,
              64'hFFFFFFFD, 64'd1, 1'b0, 1'b0);
    collect(32, "s7div-2");
    issue_exp(32, 1'b1, 64'hFFFFFFF9, 64'hFFFFFFFE,
              64'd3, 64'hFFFFFFFF, 1'b0, 1'b0);
    collect(32, "s-7div-2");
  endtask

  task automatic test_extremes();
    issue_exp(32, 1'b0, 64'hFFFFFFFF, 64'd1,
              64'hFFFFFFFF, 64'd0, 1'b0, 1'b0);
    collect(32, "umaxdiv1");
    issue_exp(32, 1'b1, 64'h80000000, 64'hFFFFFFFF,
              64'h80000000, 64'd0, 1'b0, 1'b1);
    collect(32, "smin_div_m1");
    issue_exp(32, 1'b0, 64'h80000000, 64'hFFFFFFFF,
              64'd0, 64'h80000000, 1'b0, 1'b0);
    collect(32, "u_small_by_big");
  endtask

  task automatic test_div_zero();
    issue_exp(32, 1'b0, 64'h1234, 64'd0,
              64'hFFFFFFFF, 64'h1234, 1'b1, 1'b0);
    collect(32, "dbz32");
    issue_exp(8, 1'b1, 64'h85, 64'd0, 64'hFF, 64'h85, 1'b1, 1'b0);
    collect(8, "dbz8_signed");
    issue(32, 1'b0, 64'd100, 64'd9);
    collect(32, "after_dbz");
  endtask

  task automatic test_clear_mid_run();
    int seen;
    drive(32, 1'b1, 1'b0, 64'd1000, 64'd7);
    @(posedge clock);
    #1;
    drive(32, 1'b0, 1'b0, 64'd1000, 64'd7);
    repeat (10) @(posedge clock);
    #1;
    clear = 1'b1;
    @(posedge clock);
    #1;
    clear = 1'b0;
    check_idle(32, "clear_mid_run");
    seen = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (d32.done === 1'b1) seen++;
    end
    n_vec++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL clear_no_done: got %0d done pulses, expected 0",
               seen);
    end
    issue(32, 1'b1, 64'hFFFFFC18, 64'd7);
    collect(32, "after_clear");
  endtask

  task automatic test_busy_start();
    issue(32, 1'b1, 64'hFFFFFC18, 64'd37);
    repeat (5) @(posedge clock);
    #1;
    drive(32, 1'b1, 1'b0, 64'd5, 64'd1);
    @(posedge clock);
    #1;
    drive(32, 1'b0, 1'b0, 64'd9, 64'd0);
    collect(32, "start_while_busy");
  endtask

  task automatic test_back_to_back();
    drive(32, 1'b1, 1'b0, 64'd1000, 64'd3);
    @(posedge clock);
    #1;
    push_ref(32, 1'b0, 64'd1000, 64'd3, cyc);
    drive(32, 1'b1, 1'b1, 64'hFFFFFFCE, 64'd7);
    collect(32, "b2b_first");
    @(posedge clock);
    #1;
    push_ref(32, 1'b1, 64'hFFFFFFCE, 64'd7, cyc);
    drive(32, 1'b0, 1'b0, 64'd0, 64'd0);
    n_vec++;
    if (d32.busy !== 1'b1 || d32.done !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_accept: got busy=%b done=%b, expected 1/0",
               d32.busy, d32.done);
    end
    collect(32, "b2b_second");
  endtask

  task automatic test_random();
    logic [63:0] a, b;
    logic sg;
    for (int i = 0; i < 40; i++) begin
      sg = 1'($urandom_range(0, 1));
      a  = 64'($urandom);
      b  = 64'($urandom);
      if (i % 13 == 0) b = 64'd0;
      if (i % 9 == 0)  b = b & 64'h7;
      if (i == 5) begin
        sg = 1'b1;
        a  = 64'h80;
        b  = 64'hFF;
      end
      issue(8, sg, a, b);
      collect(8, "rand8");
    end
    for (int i = 0; i < 16; i++) begin
      sg = 1'($urandom_range(0, 1));
      a  = 64'($urandom);
      b  = 64'($urandom);
      if (i % 4 == 1) b = b & 64'hFF;
      if (i % 4 == 2) b = b | 64'hFFFFFF00;
      issue(32, sg, a, b);
      collect(32, "rand32");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_extremes();
    test_div_zero();
    test_clear_mid_run();
    test_busy_start();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
